// File: rtl/key_entry_decoder_if.sv
// Downstream handshake for confirmed item codes: code_out is offered with
// code_valid and accepted on any clk edge where code_ready is also high.
interface key_entry_decoder_if #(
  parameter int DIGITS = 4
);
  logic [2*DIGITS-1:0] code_out;
  logic                code_valid;
  logic                code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/key_entry_decoder.sv
// Edge-detects entry/command keys, assembles a base-4 item code and offers
// the confirmed code downstream, holding it until the handshake completes.
module key_entry_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          KEY_Reg,
  input  logic [3:0]          CMD_Reg,
  output logic [2*DIGITS-1:0] entry_code,
  output logic [2:0]          digit_count,
  output logic                err_pulse,
  key_entry_decoder_if.master bus
);
  localparam int W = 2 * DIGITS;

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

  state_t       state;
  logic [3:0]   key_prev, cmd_prev;
  logic [3:0]   kpress, cpress;
  logic         key_one, full;
  logic [1:0]   key_val;
  logic [W-1:0] appended;

  always_comb begin
    kpress   = KEY_Reg & ~key_prev;
    cpress   = CMD_Reg & ~cmd_prev;
    key_one  = (kpress == 4'b0001) || (kpress == 4'b0010) ||
               (kpress == 4'b0100) || (kpress == 4'b1000);
    key_val  = 2'd0;
    case (kpress)
      4'b0010: key_val = 2'd1;
      4'b0100: key_val = 2'd2;
      4'b1000: key_val = 2'd3;
      default: key_val = 2'd0;
    endcase
    // Truncating cast keeps this legal for DIGITS=1, where no old digit survives.
    appended = W'({entry_code, key_val});
    full     = (digit_count == 3'(DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      key_prev       <= '0;
      cmd_prev       <= '0;
      entry_code     <= '0;
      digit_count    <= '0;
      bus.code_out   <= '0;
      bus.code_valid <= 1'b0;
      err_pulse      <= 1'b0;
    end else begin
      key_prev  <= KEY_Reg;
      cmd_prev  <= CMD_Reg;
      err_pulse <= 1'b0;
      case (state)
        HOLD: begin
          // Any press other than cancel is rejected, even on the handshake edge.
          if ((cpress != '0 && !cpress[3]) || (cpress == '0 && kpress != '0))
            err_pulse <= 1'b1;
          if (bus.code_ready || cpress[3]) begin
            bus.code_valid <= 1'b0;
            entry_code     <= '0;
            digit_count    <= '0;
            state          <= IDLE;
          end
        end
        IDLE, ENTRY: begin
          if (cpress[3] || cpress[2]) begin
            entry_code  <= '0;
            digit_count <= '0;
            state       <= IDLE;
          end else if (cpress[1]) begin
            if (state == ENTRY) begin
              entry_code  <= entry_code >> 2;
              digit_count <= digit_count - 3'd1;
              if (digit_count == 3'd1) state <= IDLE;
            end
          end else if (cpress[0]) begin
            if (state == ENTRY) begin
              bus.code_out   <= entry_code;
              bus.code_valid <= 1'b1;
              state          <= HOLD;
            end else begin
              err_pulse <= 1'b1;
            end
          end else if (kpress != '0) begin
            if (!key_one || full) begin
              err_pulse <= 1'b1;
            end else begin
              entry_code  <= appended;
              digit_count <= digit_count + 3'd1;
              state       <= ENTRY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/key_entry_decoder.md
Name: key_entry_decoder

Overview:
Consumer of the debounced, mode-split button vectors (KEY_Reg entry keys, CMD_Reg command keys) produced upstream of the sale terminal datapath. It edge-detects presses, assembles entry-key presses into a base-4 item code of up to DIGITS digits, and executes backspace/clear/cancel/confirm commands. A confirmed code is offered downstream on a valid/ready handshake and held stable until it is accepted.

Parameters:
DIGITS, 4, maximum number of base-4 digits in one code; legal range 1..7.

Ports:
clk  in  1  system clock; all inputs are synchronous to it.
rst_n  in  1  asynchronous, active-low reset.
KEY_Reg  in  4  entry key levels, active-high; bit i pressed means digit value i.
CMD_Reg  in  4  command key levels, active-high; [0] confirm, [1] backspace, [2] clear, [3] cancel.
entry_code  out  2*DIGITS  live code being typed, for display; newest digit in bits [1:0].
digit_count  out  3  number of digits currently held, 0..DIGITS.
code_out  out  2*DIGITS  confirmed code; meaningful only while code_valid=1.
code_valid  out  1  confirmed code offered downstream.
code_ready  in  1  downstream accepts code_out when high together with code_valid at a clk edge.
err_pulse  out  1  one-cycle pulse on any rejected press.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. entry_code, digit_count, code_out, code_valid and err_pulse are all 0. Previous-level registers for KEY_Reg and CMD_Reg are 0.
- Edge detection: kpress = KEY_Reg & ~key_prev and cpress = CMD_Reg & ~cmd_prev. The prev registers update every cycle.
- A level first sampled high at edge N acts at edge N; its effect is visible after edge N (latency 1 edge). A held level acts once only. A level still held through reset release registers as a press at the first edge after release.
- Command priority when several cpress bits are set: cancel > clear > backspace > confirm. Only the highest-priority command executes.
- If cpress is nonzero in a cycle, kpress is ignored in that cycle (no error).
- kpress with more than one bit set: ignored, err_pulse=1.
- States:
  - IDLE: digit_count=0.
  - ENTRY: digit_count between 1 and DIGITS.
  - HOLD: code_valid=1.
- Digit press (exactly one kpress bit, value d) in IDLE or ENTRY with digit_count<DIGITS: entry_code <= {entry_code[2*DIGITS-3:0], d}, digit_count+1, state=ENTRY.
- Digit press when digit_count==DIGITS: ignored, err_pulse=1.
- Confirm:
  - In ENTRY: code_out <= entry_code, code_valid <= 1, state=HOLD. entry_code and digit_count keep their values for display.
  - In IDLE: err_pulse=1, no state change.
- Backspace:
  - In ENTRY: entry_code >> 2 (zero-fill), digit_count-1; when digit_count reaches 0, state=IDLE.
  - In IDLE: no effect, no error.
- Clear:
  - In ENTRY: entry_code=0, digit_count=0, state=IDLE.
  - In IDLE: no effect.
- Cancel:
  - In any state: entry_code=0, digit_count=0, code_valid=0, state=IDLE.
- HOLD:
  - code_out and code_valid are stable until the handshake completes.
  - Handshake (code_valid & code_ready at an edge): code_valid=0, entry_code=0, digit_count=0, state=IDLE.
  - Digit, backspace, clear or confirm presses in HOLD: ignored, err_pulse=1.
  - Handshake and cancel in the same cycle: the handshake completes (transfer counts); the resulting state is IDLE.
- err_pulse: high for exactly the one cycle following the offending edge; never high two cycles running from a single press.
- digit_count is 3 bits wide regardless of DIGITS; upper bits are zero where not needed.

Test Plan:
- Reset then KEY_Reg press sequence 1, 3, 0, 2 (one key per press, released between presses) -> entry_code=8'b01_11_00_10=0x72, digit_count=4, state ENTRY, err_pulse never high.
- After 0x72, press KEY_Reg[1] a fifth time -> err_pulse single-cycle high, entry_code stays 0x72. Then CMD[1] (backspace) -> entry_code=0x1C, digit_count=3.
- Enter 2, 2, then confirm with code_ready=0 for 5 cycles -> code_valid=1 and code_out=0x0A held constant. Pressing KEY_Reg[0] in this window -> err_pulse. Then code_ready=1 for one cycle -> code_valid=0, digit_count=0.
- CMD_Reg=4'b1001 rising together (cancel+confirm) during ENTRY -> cancel wins: IDLE, code_valid stays 0. Also, KEY_Reg=4'b0110 rising together -> err_pulse, no digit added.
- In HOLD, assert code_ready and cancel in the same cycle -> the transfer is accepted (code_valid and code_ready both high at that edge), then IDLE. Separately, hold KEY_Reg[2] high for 20 cycles -> exactly one digit is appended.
- Assert rst_n=0 asynchronously mid-HOLD, between clock edges -> code_valid drops immediately and all outputs are 0. After release with KEY_Reg[3] still held -> digit 3 is appended once.
